// File: rtl/kyber_ntt_pkg.sv
// kyber_ntt_pkg: shared twiddle-table sizes, scheduler state encoding and client indices
package kyber_ntt_pkg;
    localparam int WIDTH = 96;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] PARK_ADDR = AW'(DEPTH - 1);
    localparam int CL_NTT  = 0;
    localparam int CL_INTT = 1;
    typedef enum logic [1:0] {EMPTY, LOAD, READY} sched_state_t;
endpackage

// File: rtl/twiddle_mem.sv
// twiddle_mem: DEPTH x WIDTH register memory, registered read, write every cycle
// Same-address write data is forwarded to the read port.
module twiddle_mem
    import kyber_ntt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q[waddr_i] <= wdata_i;
            rdata_q        <= (raddr_i == waddr_i) ? wdata_i : mem_q[raddr_i];
        end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/twiddle_sched.sv
// twiddle_sched: twiddle table loader and two-client read arbiter for the Kyber NTT datapath
// Define TWIDDLE_SCHED_RR_EN for round-robin ties; otherwise client 0 always wins ties.
module twiddle_sched
    import kyber_ntt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             table_ready,
    input  logic [1:0]       req,
    input  logic [AW-1:0]    req_addr0,
    input  logic [AW-1:0]    req_addr1,
    output logic [1:0]       gnt,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);
    sched_state_t     state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             table_ready_q, rsp_valid_q, rsp_id_q, rsp_err_q;
    logic             beat, tie;
    logic [1:0]       tie_pick;
    logic [AW-1:0]    waddr, raddr;
    logic [WIDTH-1:0] wdata, rdata;

    assign beat = (state_q == LOAD) && load_valid;
    assign tie  = (state_q == READY) && (req == 2'b11);

`ifdef TWIDDLE_SCHED_RR_EN
    logic last_gnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last_gnt_q <= 1'b1;
        else if (tie)
            last_gnt_q <= gnt[CL_INTT];
    assign tie_pick = last_gnt_q ? 2'(1 << CL_NTT) : 2'(1 << CL_INTT);
`else
    assign tie_pick = 2'(1 << CL_NTT);
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q       <= EMPTY;
            cnt_q         <= '0;
            table_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            table_ready_q <= (state_d == READY);
            rsp_valid_q   <= |gnt;
            rsp_id_q      <= gnt[CL_INTT];
            rsp_err_q     <= (|gnt) && (raddr == PARK_ADDR);
        end

    always_comb begin
        state_d = load_start ? LOAD :
                  (beat && cnt_q == AW'(DEPTH - 2)) ? READY : state_q;
        cnt_d   = load_start ? '0 : beat ? cnt_q + 1'b1 : cnt_q;
    end

    // Idle cycles park the write port on the reserved slot so the table is never disturbed.
    always_comb begin
        load_ready = (state_q == LOAD);
        gnt        = (state_q != READY) ? 2'b00 : tie ? tie_pick : req;
        raddr      = gnt[CL_INTT] ? req_addr1 : req_addr0;
        waddr      = beat ? cnt_q : PARK_ADDR;
        wdata      = beat ? load_data : '0;
    end

    twiddle_mem u_mem (
        .clk     (clk),
        .rst     (rst),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign table_ready = table_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_data    = (rsp_valid_q && !rsp_err_q) ? rdata : '0;
endmodule

// File: tb/tb_twiddle_sched.sv
// tb_twiddle_sched: randomized scoreboard bench for twiddle_sched against a table-level model
module tb_twiddle_sched;
    import kyber_ntt_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_start = 1'b0, load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready, table_ready;
    logic [1:0]       req = 2'b00;
    logic [AW-1:0]    req_addr0 = '0, req_addr1 = '0;
    logic [1:0]       gnt;
    logic             rsp_valid, rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_data;

    twiddle_sched dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .table_ready(table_ready),
        .req(req), .req_addr0(req_addr0), .req_addr1(req_addr1), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

`ifdef TWIDDLE_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int               due;
        logic             id;
        logic [WIDTH-1:0] data;
        logic             err;
    } rsp_t;

    rsp_t             sbq[$];
    int               n_cmp = 0, n_bad = 0, cyc = 0;
    bit               started = 1'b0;
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               m_state = 0, m_cnt = 0;
    logic             m_last = 1'b1;
    logic [1:0]       exp_gnt = 2'b00, last_g = 2'b00;
    logic             exp_lr = 1'b0, exp_tr = 1'b0;
    logic [1:0]       pend = 2'b00;
    logic [AW-1:0]    paddr [2] = '{default: '0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // model states: 0 empty, 1 loading, 2 table ready
    function automatic logic [1:0] arb(input logic [1:0] rq);
        if (m_state != 2) return 2'b00;
        if (rq == 2'b11) return (RR && !m_last) ? 2'b10 : 2'b01;
        return rq;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_state = 0; m_cnt = 0; m_last = 1'b1;
        sbq.delete();
        exp_gnt = 2'b00; exp_lr = 1'b0; exp_tr = 1'b0;
    endtask

    task automatic cyc_step(input logic ls, input logic lv, input logic [WIDTH-1:0] ld,
                            input logic [1:0] rq, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [1:0]    g;
        logic [AW-1:0] a;
        load_start = ls; load_valid = lv; load_data = ld;
        req = rq; req_addr0 = a0; req_addr1 = a1;
        g = arb(rq);
        exp_gnt = g;
        exp_lr  = (m_state == 1);
        exp_tr  = (m_state == 2);
        if (g != 2'b00) begin
            a = g[1] ? a1 : a0;
            sbq.push_back('{due: cyc + 1, id: g[1], data: (a == AW'(DEPTH - 1)) ? '0 : ref_mem[a],
                            err: (a == AW'(DEPTH - 1))});
            if (rq == 2'b11) m_last = g[1];
        end
        if (m_state == 1 && lv) begin
            ref_mem[m_cnt] = ld;
            if (m_cnt == DEPTH - 2) m_state = 2;
            m_cnt++;
        end
        if (ls) begin m_state = 1; m_cnt = 0; end
        last_g = g;
        @(posedge clk); #1;
    endtask

    task automatic tick(input logic ls, input logic lv, input logic [WIDTH-1:0] ld);
        cyc_step(ls, lv, ld, pend, paddr[0], paddr[1]);
        pend = pend & ~last_g;
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic load_table(input bit rnd, input int beats);
        int i = 0;
        tick(1'b1, 1'b0, rnd_word());
        while (i < beats) begin
            logic lv = ($urandom_range(0, 3) != 0);
            tick(1'b0, lv, lv ? (rnd ? rnd_word() : WIDTH'(i * 'h111)) : rnd_word());
            if (lv) i++;
        end
    endtask

    task automatic read(input int c, input int addr);
        pend[c] = 1'b1;
        paddr[c] = AW'(addr);
        tick(1'b0, 1'b0, '0);
    endtask

    task automatic traffic(input int n);
        repeat (n) begin
            for (int c = 0; c < 2; c++)
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c] = 1'b1;
                    paddr[c] = AW'($urandom_range(0, DEPTH - 1));
                end
            tick(1'b0, 1'b0, rnd_word());
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, '0);
        chk({tag, "_rsp_id"}, rsp_id, '0);
        chk({tag, "_rsp_data"}, rsp_data, '0);
        chk({tag, "_rsp_err"}, rsp_err, '0);
        chk({tag, "_gnt"}, gnt, '0);
        chk({tag, "_table_ready"}, table_ready, '0);
        chk({tag, "_load_ready"}, load_ready, '0);
    endtask

    always @(negedge clk) if (started) begin
        rsp_t e;
        chk("gnt", gnt, exp_gnt);
        chk("load_ready", load_ready, exp_lr);
        chk("table_ready", table_ready, exp_tr);
        if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("rsp_valid", rsp_valid, 1'b1);
            if (rsp_valid) begin
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
            end
        end else
            chk("rsp_valid_idle", rsp_valid, 1'b0);
    end

    initial begin
        model_reset();
        req = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        req = 2'b00;
        started = 1'b1;
        tick(1'b0, 1'b0, '0);

        load_table(1'b0, DEPTH - 1);
        tick(1'b0, 1'b0, '0);
        read(0, 30);
        tick(1'b0, 1'b0, '0);

        repeat (4) begin
            pend = 2'b11; paddr[0] = 5; paddr[1] = 7;
            tick(1'b0, 1'b0, '0);
        end
        pend = 2'b00;
        read(1, DEPTH - 1);
        tick(1'b0, 1'b0, '0);

        pend = 2'b11; paddr[0] = 3; paddr[1] = 9;
        tick(1'b1, 1'b0, rnd_word());
        for (int i = 0; i < DEPTH - 1; ) begin
            logic lv = ($urandom_range(0, 3) != 0);
            pend = 2'b11;
            tick(1'b0, lv, rnd_word());
            if (lv) i++;
        end
        pend = 2'b00;
        read(0, 3);
        traffic(150);

        pend = 2'b00;
        load_table(1'b1, 10);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_rsp_valid", rsp_valid, '0);
        chk("midrst_table_ready", table_ready, '0);
        pend = 2'b11;
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        rst = 1'b0;
        tick(1'b0, 1'b0, '0);
        pend = 2'b11;
        load_table(1'b1, DEPTH - 1);
        traffic(200);
        pend = 2'b00;
        load_table(1'b1, DEPTH - 1);
        traffic(150);
        pend = 2'b00;
        repeat (3) tick(1'b0, 1'b0, '0);
        chk("drain", WIDTH'(sbq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/twiddle_sched.md
# twiddle_sched

Twiddle-factor table controller for the Kyber NTT/INTT datapath. It owns a 32×96-bit twiddle memory and loads its 31 usable entries from a streaming source. It then arbitrates single-word read requests from two butterfly clients (client 0 = forward NTT, client 1 = INTT). Each granted read returns a tagged response one cycle later.

## Interface
- DEPTH, 32: memory words. Entries 0..DEPTH-2 hold table data; entry DEPTH-1 is the reserved write-parking slot.
- WIDTH, 96: word width (8×12-bit coefficients).
- AW, 5: address width, clog2(DEPTH).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  pulse; starts or restarts the table load.
- load_valid  in  1  load word valid.
- load_data  in  WIDTH  load word.
- load_ready  out  1  load word accepted when high together with load_valid.
- table_ready  out  1  table fully loaded; reads may be served.
- req  in  2  per-client read request, level, held until granted.
- req_addr0, req_addr1  in  AW  per-client word address.
- gnt  out  2  one-hot grant, combinational, same cycle as the accepted request.
- rsp_valid  out  1  response valid.
- rsp_id  out  1  client index for the response.
- rsp_data  out  WIDTH  response word.
- rsp_err  out  1  response addressed the parking slot.

## Operation
- States: EMPTY (after reset), LOAD, READY.
- EMPTY→LOAD and READY→LOAD on load_start. load_start in LOAD restarts the load at count 0. Entries that are not rewritten keep their old data.
- LOAD:
  - load_ready=1.
  - Each load_valid&&load_ready writes load_data to entry cnt, then cnt++.
  - The write of entry DEPTH-2 moves the state to READY.
- Memory write port writes every cycle, unconditionally:
  - In LOAD: wdata_addr=cnt, wdata=load_data. When load_valid=0, the controller parks instead of writing.
  - Otherwise the controller parks: wdata_addr=DEPTH-1, wdata=0.
- Arbitration: only in READY. gnt=0 in EMPTY/LOAD; requests wait.
  - One requester: it is granted.
  - Both requesting: grant goes to the client that is not last_gnt, then last_gnt updates.
  - Granted address drives the memory read address.
- Granted address DEPTH-1: rsp_err=1 and rsp_data forced to 0.
- Out-of-range is only DEPTH-1; the address width permits no other.
- The memory forwards wdata when read and write addresses match. Only the parking slot can collide, and that read is masked, so forwarding is never visible.

## Timing
- Reset values:
  - state=EMPTY, cnt=0, last_gnt=1 (client 0 wins the first tie).
  - load_ready=0, table_ready=0, gnt=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - All memory words cleared.
- table_ready is registered. It rises the cycle after the final load beat and falls the cycle after load_start.
- Read latency 1: grant in cycle N gives rsp_valid/rsp_id/rsp_err/rsp_data in N+1.
- One grant per cycle gives full throughput; back-to-back grants give back-to-back responses.
- Load beat in cycle N; a read of that entry granted in N+1 or later returns the new data.
- A grant in the cycle load_start arrives is still honoured, and its response is delivered.
- rst mid-LOAD returns to EMPTY with table cleared. A response in flight is dropped.

## Configuration
- TWIDDLE_SCHED_RR_EN
  - Defined: round-robin as above.
  - Undefined: fixed priority, client 0 always wins ties; last_gnt is removed.

## Structure
- Shared package kyber_ntt_pkg holds:
  - WIDTH, DEPTH, AW, PARK_ADDR=DEPTH-1.
  - State enum sched_state_t {EMPTY, LOAD, READY}.
  - Client index constants CL_NTT=0, CL_INTT=1.
- Sub-module twiddle_mem:
  - DEPTH×WIDTH, registered read, unconditional write each cycle.
  - Same-address write-to-read forwarding.
  - Async reset clears all words and rdata.

## Test plan
- Load: load_start, then 31 beats of data i·0x111 with load_valid gaps → table_ready rises the cycle after beat 30. Client 0 reads addr 30 → rsp_data=30·0x111, rsp_id=0, one cycle after gnt.
- Tie: both clients hold req, addr0=5, addr1=7, four cycles → gnt 01,10,01,10. Responses 5·0x111, 7·0x111 alternate with matching rsp_id.
- Parking: client 1 reads addr 31 → rsp_err=1, rsp_data=0, rsp_id=1.
- Reload: load_start while READY with req held → gnt=0 during LOAD. After reload with new data, a read of addr 3 returns the new word.
- rst mid-load after 10 beats → all outputs 0, state EMPTY, req ignored. A full reload then reads correctly.
- Macro undefined, both clients requesting for 3 cycles → gnt=01 each cycle.
